// File: rtl/pc_branch_unit.sv
// Fetch-side PC generator: branch resolution, redirect-pending buffer and imem req/ready handshake.
// Optional feature: define MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_PC.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [2:0]  BranchType,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] PCEx,
    input  logic [31:0] ImmExt,
    input  logic [31:0] SrcA,
    input  logic        ZF,
    input  logic        SF,
    input  logic        IReady,
    output logic        IReq,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        PCSrc,
    output logic        Flush,
    output logic        MisalignErr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic        ireq_q, ireq_d;
    logic        flush_q, flush_d;
    logic        merr_q, merr_d;

    logic        cond_s;
    logic        pcsrc_s;
    logic        capture_s;
    logic        advance_s;
    logic        misalign_s;
    logic [31:0] target_raw_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;

    // Branch condition decode and redirect target computation.
    always_comb begin
        cond_s = 1'b0;
        case (BranchType)
            3'b000:  cond_s = ZF;
            3'b001:  cond_s = ~ZF;
            3'b100:  cond_s = SF;
            3'b101:  cond_s = ~SF;
            default: cond_s = 1'b0;
        endcase
        pcsrc_s = Jump | JumpReg | (Branch & cond_s);
        if (JumpReg) begin
            target_raw_s = (SrcA + ImmExt) & 32'hFFFF_FFFE;
        end else begin
            target_raw_s = PCEx + ImmExt;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = |target_raw_s[1:0];
    assign target_s   = misalign_s ? TRAP_PC : target_raw_s;
`else
    logic unused_trap_s;
    assign unused_trap_s = ^TRAP_PC;
    assign misalign_s    = 1'b0;
    assign target_s      = target_raw_s;
`endif

    // An older pending redirect wins; anything redirecting behind it is wrong-path.
    assign capture_s  = pcsrc_s & ~pend_valid_q;
    assign pc_plus4_s = pc_q + 32'd4;
    assign next_pc_s  = pend_valid_q ? pend_target_q : pc_plus4_s;

    // Fetch FSM next-state and advance decision.
    always_comb begin
        state_d   = state_q;
        advance_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (IReady) begin
                    if (Stall) begin
                        state_d = ST_STALL;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_STALL: begin
                if (!Stall) begin
                    advance_s = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC, pending-redirect buffer and pulse outputs next-state.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q | capture_s;
        pend_target_d = pend_target_q;
        if (advance_s) begin
            pc_d         = next_pc_s;
            pend_valid_d = capture_s;
        end else begin
            pc_d = pc_q;
        end
        if (capture_s) begin
            pend_target_d = target_s;
        end else begin
            pend_target_d = pend_target_q;
        end
        flush_d = capture_s;
        merr_d  = capture_s & misalign_s;
        ireq_d  = (state_d == ST_FETCH);
    end

    // State registers; async reset drops IReq immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            pend_valid_q  <= 1'b0;
            ireq_q        <= 1'b0;
            flush_q       <= 1'b0;
            merr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            ireq_q        <= ireq_d;
            flush_q       <= flush_d;
            merr_q        <= merr_d;
        end
    end

    assign IReq        = ireq_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4_s;
    assign PCSrc       = pcsrc_s;
    assign Flush       = flush_q;
    assign MisalignErr = merr_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Table-driven bench for pc_branch_unit: one record per cycle, expectations queued and
// compared by a negedge monitor; async reset checked by hand.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, Branch, Jump, JumpReg, ZF, SF, IReady;
    logic [2:0]  BranchType;
    logic [31:0] PCEx, ImmExt, SrcA;
    logic        IReq, PCSrc, Flush, MisalignErr;
    logic [31:0] PC, PCPlus4;

    pc_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Branch(Branch), .BranchType(BranchType),
        .Jump(Jump), .JumpReg(JumpReg), .PCEx(PCEx), .ImmExt(ImmExt), .SrcA(SrcA),
        .ZF(ZF), .SF(SF), .IReady(IReady), .IReq(IReq), .PC(PC), .PCPlus4(PCPlus4),
        .PCSrc(PCSrc), .Flush(Flush), .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_0100;
    localparam logic        MIS_ERR = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_0106;
    localparam logic        MIS_ERR = 1'b0;
`endif

    typedef struct packed {
        logic        stall;
        logic        iready;
        logic        br;
        logic [2:0]  bt;
        logic        jmp;
        logic        jr;
        logic [31:0] pcex;
        logic [31:0] imm;
        logic [31:0] srca;
        logic        zf;
        logic        sf;
        logic        e_pcsrc;
        logic [31:0] e_pc;
        logic        e_ireq;
        logic        e_flush;
        logic        e_merr;
        logic [7:0]  id;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t rst_vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec %0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t nop(input logic stall, input logic iready, input logic [31:0] e_pc,
                                 input logic e_ireq, input logic e_flush);
        vec_t v;
        v = '0;
        v.stall = stall; v.iready = iready; v.e_pc = e_pc; v.e_ireq = e_ireq; v.e_flush = e_flush;
        return v;
    endfunction

    function automatic vec_t with_br(input vec_t vi, input logic [2:0] bt, input logic [31:0] pcex,
                                     input logic [31:0] imm, input logic zf, input logic sf,
                                     input logic pcsrc);
        vec_t v;
        v = vi;
        v.br = 1'b1; v.bt = bt; v.pcex = pcex; v.imm = imm; v.zf = zf; v.sf = sf; v.e_pcsrc = pcsrc;
        return v;
    endfunction

    function automatic vec_t with_jal(input vec_t vi, input logic [31:0] pcex, input logic [31:0] imm);
        vec_t v;
        v = vi;
        v.jmp = 1'b1; v.pcex = pcex; v.imm = imm; v.e_pcsrc = 1'b1;
        return v;
    endfunction

    function automatic vec_t with_jalr(input vec_t vi, input logic [31:0] srca, input logic [31:0] imm);
        vec_t v;
        v = vi;
        v.jr = 1'b1; v.srca = srca; v.imm = imm; v.pcex = 32'h0000_0FF0; v.e_pcsrc = 1'b1;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vec_t w;
        w = v;
        w.id = 8'(vecs.size());
        vecs.push_back(w);
    endtask

    task automatic drive(input vec_t v);
        Stall = v.stall; IReady = v.iready; Branch = v.br; BranchType = v.bt;
        Jump = v.jmp; JumpReg = v.jr; PCEx = v.pcex; ImmExt = v.imm; SrcA = v.srca;
        ZF = v.zf; SF = v.sf;
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare queued expectations mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            chk("pc", int'(e.id), PC, e.e_pc);
            chk("pcplus4", int'(e.id), PCPlus4, e.e_pc + 32'd4);
            chk("ireq", int'(e.id), {31'd0, IReq}, {31'd0, e.e_ireq});
            chk("pcsrc", int'(e.id), {31'd0, PCSrc}, {31'd0, e.e_pcsrc});
            chk("flush", int'(e.id), {31'd0, Flush}, {31'd0, e.e_flush});
            chk("misalign", int'(e.id), {31'd0, MisalignErr}, {31'd0, e.e_merr});
        end
    end

    initial begin
        vec_t v;
        // reset release and straight-line fetch
        add(nop(1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
        add(nop(1'b0, 1'b1, 32'h0, 1'b1, 1'b0));
        add(nop(1'b0, 1'b1, 32'h4, 1'b1, 1'b0));
        add(nop(1'b0, 1'b1, 32'h8, 1'b1, 1'b0));
        add(nop(1'b0, 1'b1, 32'hC, 1'b1, 1'b0));
        // beq taken, then beq not taken
        add(with_br(nop(1'b0, 1'b1, 32'h10, 1'b1, 1'b0), 3'b000, 32'h10, 32'h20, 1'b1, 1'b0, 1'b1));
        add(nop(1'b0, 1'b1, 32'h14, 1'b1, 1'b1));
        add(with_br(nop(1'b0, 1'b1, 32'h30, 1'b1, 1'b0), 3'b000, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0));
        add(nop(1'b0, 1'b1, 32'h34, 1'b1, 1'b0));
        // jalr aligned, then jalr landing on bit 1
        add(with_jalr(nop(1'b0, 1'b1, 32'h38, 1'b1, 1'b0), 32'h101, 32'h4));
        add(nop(1'b0, 1'b1, 32'h3C, 1'b1, 1'b1));
        add(with_jalr(nop(1'b0, 1'b1, 32'h104, 1'b1, 1'b0), 32'h102, 32'h4));
        v = nop(1'b0, 1'b1, 32'h108, 1'b1, 1'b1);
        v.e_merr = MIS_ERR;
        add(v);
        add(with_jal(nop(1'b0, 1'b1, MIS_PC, 1'b1, 1'b0), 32'h0, 32'h400));
        add(nop(1'b0, 1'b1, MIS_PC + 32'd4, 1'b1, 1'b1));
        add(nop(1'b0, 1'b1, 32'h400, 1'b1, 1'b0));
        // imem wait with blt taken mid-wait
        add(nop(1'b0, 1'b0, 32'h404, 1'b1, 1'b0));
        add(with_br(nop(1'b0, 1'b0, 32'h404, 1'b1, 1'b0), 3'b100, 32'h400, 32'h100, 1'b0, 1'b1, 1'b1));
        add(nop(1'b0, 1'b0, 32'h404, 1'b1, 1'b1));
        add(nop(1'b0, 1'b1, 32'h404, 1'b1, 1'b0));
        add(with_br(nop(1'b0, 1'b1, 32'h500, 1'b1, 1'b0), 3'b100, 32'h500, 32'h100, 1'b1, 1'b0, 1'b0));
        add(with_br(nop(1'b0, 1'b1, 32'h504, 1'b1, 1'b0), 3'b101, 32'h500, 32'hFFFF_FF00, 1'b1, 1'b0, 1'b1));
        add(nop(1'b0, 1'b1, 32'h508, 1'b1, 1'b1));
        add(with_br(nop(1'b0, 1'b1, 32'h400, 1'b1, 1'b0), 3'b010, 32'h400, 32'h40, 1'b1, 1'b1, 1'b0));
        // two-cycle stall
        add(nop(1'b1, 1'b1, 32'h404, 1'b1, 1'b0));
        add(nop(1'b1, 1'b1, 32'h404, 1'b0, 1'b0));
        add(nop(1'b0, 1'b1, 32'h404, 1'b0, 1'b0));
        add(nop(1'b0, 1'b1, 32'h408, 1'b1, 1'b0));
        // bne captured while stalled
        add(nop(1'b1, 1'b1, 32'h40C, 1'b1, 1'b0));
        add(with_br(nop(1'b1, 1'b1, 32'h40C, 1'b0, 1'b0), 3'b001, 32'h40C, 32'h74, 1'b0, 1'b1, 1'b1));
        add(nop(1'b0, 1'b1, 32'h40C, 1'b0, 1'b1));
        // double redirect: jal then bne while pending
        add(with_jal(nop(1'b0, 1'b1, 32'h480, 1'b1, 1'b0), 32'h100, 32'h100));
        add(with_br(nop(1'b0, 1'b1, 32'h484, 1'b1, 1'b1), 3'b001, 32'h200, 32'h100, 1'b0, 1'b0, 1'b1));
        add(nop(1'b0, 1'b1, 32'h200, 1'b1, 1'b0));
        // 32-bit wrap of target and of PCPlus4
        add(with_jal(nop(1'b0, 1'b1, 32'h204, 1'b1, 1'b0), 32'hFFFF_FFF0, 32'h20));
        add(nop(1'b0, 1'b1, 32'h208, 1'b1, 1'b1));
        add(with_jal(nop(1'b0, 1'b1, 32'h10, 1'b1, 1'b0), 32'h0, 32'hFFFF_FFFC));
        add(nop(1'b0, 1'b1, 32'h14, 1'b1, 1'b1));
        add(nop(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0));
        add(nop(1'b0, 1'b1, 32'h0, 1'b1, 1'b0));
        // set up a pending redirect during an imem wait, then reset
        add(with_jal(nop(1'b0, 1'b0, 32'h4, 1'b1, 1'b0), 32'h0, 32'h80));
        add(nop(1'b0, 1'b0, 32'h4, 1'b1, 1'b1));

        rst_vecs.push_back(nop(1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
        rst_vecs.push_back(nop(1'b0, 1'b1, 32'h0, 1'b1, 1'b0));
        rst_vecs.push_back(nop(1'b0, 1'b1, 32'h4, 1'b1, 1'b0));
        rst_vecs.push_back(nop(1'b0, 1'b1, 32'h8, 1'b1, 1'b0));
        for (int i = 0; i < rst_vecs.size(); i++) begin
            rst_vecs[i].id = 8'(200 + i);
        end

        rst_n = 1'b0;
        drive(nop(1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", -1, PC, 32'h0);
        chk("reset_ireq", -1, {31'd0, IReq}, 32'd0);
        chk("reset_flush", -1, {31'd0, Flush}, 32'd0);
        chk("reset_merr", -1, {31'd0, MisalignErr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // async reset mid-FETCH while waiting on imem with a redirect pending
        drive(nop(1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ireq", -2, {31'd0, IReq}, 32'd0);
        chk("async_pc", -2, PC, 32'h0);
        chk("async_flush", -2, {31'd0, Flush}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < rst_vecs.size(); i++) begin
            run_vec(rst_vecs[i]);
        end

        chk("queue_drained", -3, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
